// File: rtl/bellek_hakemi_pkg.sv
// Shared definitions for the main-memory arbiter (bellek_hakemi).
//  - durum_e : arbiter FSM states (BOSTA idle, ISTEK request out, YANIT awaiting response)
//  - sahip_e : transaction owner IDs (L1 instruction cache / L1 data cache)
//  - HIGH/LOW: readable single-bit constants
package bellek_hakemi_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_e;

  typedef enum logic {
    SAHIP_L1B = 1'b0,
    SAHIP_L1V = 1'b1
  } sahip_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/bellek_hakemi_rr_hakem_2.sv
// Two-way round-robin picker.
//  istek[0] : L1B request, istek[1] : L1V request
//  son_sahip: owner of the most recent grant
//  izin     : one-hot grant (bit 0 L1B, bit 1 L1V), all zero when nobody asks
// A sole requester always wins; on a tie the side that was not served last wins.
module rr_hakem_2
  import bellek_hakemi_pkg::*;
(
  input  logic [1:0] istek,
  input  sahip_e     son_sahip,
  output logic [1:0] izin
);

  // Grant decode: tie broken against the last owner
  always_comb begin
    izin = 2'b00;
    case (istek)
      2'b01: izin = 2'b01;
      2'b10: izin = 2'b10;
      2'b11: begin
        if (son_sahip == SAHIP_L1V) begin
          izin = 2'b01;
        end else begin
          izin = 2'b10;
        end
      end
      default: izin = 2'b00;
    endcase
  end

endmodule

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: shares one main-memory port between the L1B (instruction cache)
// miss path and the L1V (data cache) miss/writeback path. One transaction is in
// flight at a time; the winning request is latched on grant, presented to memory
// from registers, and the memory response is routed back to the owner.
// Ports:
//  clk_i, rst_i             clock, synchronous active-high reset
//  l1b_istek_*/l1b_yanit_*  L1B read request channel and read response channel
//  l1v_istek_*/l1v_yanit_*  L1V read/write request channel and response channel
//  bellek_istek_*           request channel towards memory (registered)
//  bellek_yanit_*           response channel from memory
//  l1b/l1v_istek_sayac_o    wrapping counts of granted requests per side
module bellek_hakemi
  import bellek_hakemi_pkg::*;
#(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 128,
  parameter int MASKE_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 l1b_istek_gecerli_i,
  output logic                 l1b_istek_hazir_o,
  input  logic [ADRES_BIT-1:0] l1b_istek_adres_i,
  output logic                 l1b_yanit_gecerli_o,
  output logic [VERI_BIT-1:0]  l1b_yanit_veri_o,
  input  logic                 l1b_yanit_hazir_i,
  input  logic                 l1v_istek_gecerli_i,
  output logic                 l1v_istek_hazir_o,
  input  logic [ADRES_BIT-1:0] l1v_istek_adres_i,
  input  logic                 l1v_istek_yaz_i,
  input  logic [VERI_BIT-1:0]  l1v_istek_veri_i,
  input  logic [MASKE_BIT-1:0] l1v_istek_maske_i,
  output logic                 l1v_yanit_gecerli_o,
  output logic [VERI_BIT-1:0]  l1v_yanit_veri_o,
  input  logic                 l1v_yanit_hazir_i,
  output logic                 bellek_istek_gecerli_o,
  input  logic                 bellek_istek_hazir_i,
  output logic [ADRES_BIT-1:0] bellek_istek_adres_o,
  output logic                 bellek_istek_yaz_o,
  output logic [VERI_BIT-1:0]  bellek_istek_veri_o,
  output logic [MASKE_BIT-1:0] bellek_istek_maske_o,
  input  logic                 bellek_yanit_gecerli_i,
  input  logic [VERI_BIT-1:0]  bellek_yanit_veri_i,
  output logic                 bellek_yanit_hazir_o,
  output logic [31:0]          l1b_istek_sayac_o,
  output logic [31:0]          l1v_istek_sayac_o
);

  durum_e               durum_r;
  sahip_e               son_sahip_r;
  sahip_e               sahip_r;
  logic                 istek_gecerli_r;
  logic [ADRES_BIT-1:0] adres_r;
  logic                 yaz_r;
  logic [VERI_BIT-1:0]  veri_r;
  logic [MASKE_BIT-1:0] maske_r;
  logic [31:0]          l1b_sayac_r;
  logic [31:0]          l1v_sayac_r;
  logic [1:0]           izin_s;
  logic                 yanit_el_sikisma_s;

  rr_hakem_2 u_hakem (
    .istek     ({l1v_istek_gecerli_i, l1b_istek_gecerli_i}),
    .son_sahip (son_sahip_r),
    .izin      (izin_s)
  );

  // The memory request is driven purely from the latched copy so it stays stable under backpressure
  assign bellek_istek_gecerli_o = istek_gecerli_r;
  assign bellek_istek_adres_o   = adres_r;
  assign bellek_istek_yaz_o     = yaz_r;
  assign bellek_istek_veri_o    = veri_r;
  assign bellek_istek_maske_o   = maske_r;
  assign l1b_istek_sayac_o      = l1b_sayac_r;
  assign l1v_istek_sayac_o      = l1v_sayac_r;

  // Response data goes straight through; only the owner's valid is raised, so the other side ignores it
  assign l1b_yanit_veri_o = bellek_yanit_veri_i;
  assign l1v_yanit_veri_o = bellek_yanit_veri_i;

  assign yanit_el_sikisma_s = (durum_r == YANIT) && bellek_yanit_gecerli_i && bellek_yanit_hazir_o;

  // Grant acceptance and response routing towards the caches
  always_comb begin
    l1b_istek_hazir_o    = LOW;
    l1v_istek_hazir_o    = LOW;
    l1b_yanit_gecerli_o  = LOW;
    l1v_yanit_gecerli_o  = LOW;
    bellek_yanit_hazir_o = LOW;
    if (durum_r == BOSTA) begin
      l1b_istek_hazir_o = izin_s[0];
      l1v_istek_hazir_o = izin_s[1];
    end else begin
      l1b_istek_hazir_o = LOW;
      l1v_istek_hazir_o = LOW;
    end
    // A memory response arriving outside YANIT is a protocol violation and is never consumed
    if (durum_r == YANIT) begin
      if (sahip_r == SAHIP_L1B) begin
        l1b_yanit_gecerli_o  = bellek_yanit_gecerli_i;
        bellek_yanit_hazir_o = l1b_yanit_hazir_i;
      end else begin
        l1v_yanit_gecerli_o  = bellek_yanit_gecerli_i;
        bellek_yanit_hazir_o = l1v_yanit_hazir_i;
      end
    end else begin
      bellek_yanit_hazir_o = LOW;
    end
  end

  // Arbiter FSM: grant and latch, hold request until accepted, wait for the single response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r         <= BOSTA;
      son_sahip_r     <= SAHIP_L1V;
      sahip_r         <= SAHIP_L1B;
      istek_gecerli_r <= LOW;
      adres_r         <= {ADRES_BIT{1'b0}};
      yaz_r           <= LOW;
      veri_r          <= {VERI_BIT{1'b0}};
      maske_r         <= {MASKE_BIT{1'b0}};
      l1b_sayac_r     <= 32'd0;
      l1v_sayac_r     <= 32'd0;
    end else begin
      case (durum_r)
        BOSTA: begin
          if (izin_s[0]) begin
            adres_r         <= l1b_istek_adres_i;
            yaz_r           <= LOW;
            veri_r          <= {VERI_BIT{1'b0}};
            maske_r         <= {MASKE_BIT{1'b0}};
            sahip_r         <= SAHIP_L1B;
            son_sahip_r     <= SAHIP_L1B;
            l1b_sayac_r     <= l1b_sayac_r + 32'd1;
            istek_gecerli_r <= HIGH;
            durum_r         <= ISTEK;
          end else if (izin_s[1]) begin
            adres_r         <= l1v_istek_adres_i;
            yaz_r           <= l1v_istek_yaz_i;
            veri_r          <= l1v_istek_veri_i;
            maske_r         <= l1v_istek_maske_i;
            sahip_r         <= SAHIP_L1V;
            son_sahip_r     <= SAHIP_L1V;
            l1v_sayac_r     <= l1v_sayac_r + 32'd1;
            istek_gecerli_r <= HIGH;
            durum_r         <= ISTEK;
          end else begin
            durum_r <= BOSTA;
          end
        end
        ISTEK: begin
          if (bellek_istek_hazir_i) begin
            istek_gecerli_r <= LOW;
            durum_r         <= YANIT;
          end else begin
            durum_r <= ISTEK;
          end
        end
        YANIT: begin
          if (yanit_el_sikisma_s) begin
            durum_r <= BOSTA;
          end else begin
            durum_r <= YANIT;
          end
        end
        default: begin
          istek_gecerli_r <= LOW;
          durum_r         <= BOSTA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Self-checking bench for bellek_hakemi. A small arbitration model decides the
// expected winner; each grant pushes the expected memory request to a queue that
// is popped and compared while the bench plays the memory side.
module tb_bellek_hakemi;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         l1b_istek_gecerli_i, l1b_istek_hazir_o;
  logic [31:0]  l1b_istek_adres_i;
  logic         l1b_yanit_gecerli_o;
  logic [127:0] l1b_yanit_veri_o;
  logic         l1b_yanit_hazir_i;
  logic         l1v_istek_gecerli_i, l1v_istek_hazir_o;
  logic [31:0]  l1v_istek_adres_i;
  logic         l1v_istek_yaz_i;
  logic [127:0] l1v_istek_veri_i;
  logic [15:0]  l1v_istek_maske_i;
  logic         l1v_yanit_gecerli_o;
  logic [127:0] l1v_yanit_veri_o;
  logic         l1v_yanit_hazir_i;
  logic         bellek_istek_gecerli_o, bellek_istek_hazir_i;
  logic [31:0]  bellek_istek_adres_o;
  logic         bellek_istek_yaz_o;
  logic [127:0] bellek_istek_veri_o;
  logic [15:0]  bellek_istek_maske_o;
  logic         bellek_yanit_gecerli_i;
  logic [127:0] bellek_yanit_veri_i;
  logic         bellek_yanit_hazir_o;
  logic [31:0]  l1b_istek_sayac_o, l1v_istek_sayac_o;

  bellek_hakemi dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .l1b_istek_gecerli_i(l1b_istek_gecerli_i), .l1b_istek_hazir_o(l1b_istek_hazir_o),
    .l1b_istek_adres_i(l1b_istek_adres_i), .l1b_yanit_gecerli_o(l1b_yanit_gecerli_o),
    .l1b_yanit_veri_o(l1b_yanit_veri_o), .l1b_yanit_hazir_i(l1b_yanit_hazir_i),
    .l1v_istek_gecerli_i(l1v_istek_gecerli_i), .l1v_istek_hazir_o(l1v_istek_hazir_o),
    .l1v_istek_adres_i(l1v_istek_adres_i), .l1v_istek_yaz_i(l1v_istek_yaz_i),
    .l1v_istek_veri_i(l1v_istek_veri_i), .l1v_istek_maske_i(l1v_istek_maske_i),
    .l1v_yanit_gecerli_o(l1v_yanit_gecerli_o), .l1v_yanit_veri_o(l1v_yanit_veri_o),
    .l1v_yanit_hazir_i(l1v_yanit_hazir_i),
    .bellek_istek_gecerli_o(bellek_istek_gecerli_o), .bellek_istek_hazir_i(bellek_istek_hazir_i),
    .bellek_istek_adres_o(bellek_istek_adres_o), .bellek_istek_yaz_o(bellek_istek_yaz_o),
    .bellek_istek_veri_o(bellek_istek_veri_o), .bellek_istek_maske_o(bellek_istek_maske_o),
    .bellek_yanit_gecerli_i(bellek_yanit_gecerli_i), .bellek_yanit_veri_i(bellek_yanit_veri_i),
    .bellek_yanit_hazir_o(bellek_yanit_hazir_o),
    .l1b_istek_sayac_o(l1b_istek_sayac_o), .l1v_istek_sayac_o(l1v_istek_sayac_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         sahip;   // 0 = L1B, 1 = L1V
    logic [31:0]  adres;
    logic         yaz;
    logic [127:0] veri;
    logic [15:0]  maske;
  } beklenen_t;

  beklenen_t   istek_q[$];
  int          vektor_sayisi = 0;
  int          hata_sayisi   = 0;
  logic        son_m;          // model of last owner
  logic [31:0] sayac_b_m, sayac_v_m;

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    vektor_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %h expected %h at %0t", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic saat();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_sifirla();
    son_m     = 1'b1;
    sayac_b_m = 32'd0;
    sayac_v_m = 32'd0;
    istek_q.delete();
  endtask

  task automatic sifirla();
    rst_i = 1'b1;
    repeat (2) saat();
    rst_i = 1'b0;
    model_sifirla();
    kontrol("rst_istek_gecerli", bellek_istek_gecerli_o, 1'b0);
    kontrol("rst_yanit_gecerli", {l1b_yanit_gecerli_o, l1v_yanit_gecerli_o}, 2'b00);
    kontrol("rst_sayac_b", l1b_istek_sayac_o, 32'd0);
    kontrol("rst_sayac_v", l1v_istek_sayac_o, 32'd0);
  endtask

  // Present requests for one cycle, check the grant against the model, record the expected request
  task automatic tahkim(input logic b, input logic v, input logic [31:0] badr, input logic [31:0] vadr,
                        input logic vyaz, input logic [127:0] vveri, input logic [15:0] vmaske);
    int kaz;
    beklenen_t e;
    l1b_istek_gecerli_i = b;   l1b_istek_adres_i = badr;
    l1v_istek_gecerli_i = v;   l1v_istek_adres_i = vadr;
    l1v_istek_yaz_i = vyaz;    l1v_istek_veri_i = vveri;  l1v_istek_maske_i = vmaske;
    #1;
    kaz = -1;
    if (b && (!v || son_m == 1'b1)) kaz = 0;
    else if (v) kaz = 1;
    kontrol("l1b_hazir", l1b_istek_hazir_o, kaz == 0);
    kontrol("l1v_hazir", l1v_istek_hazir_o, kaz == 1);
    if (kaz == 0) begin
      e = '{sahip: 1'b0, adres: badr, yaz: 1'b0, veri: 128'd0, maske: 16'd0};
      istek_q.push_back(e);
      son_m = 1'b0;
      sayac_b_m = sayac_b_m + 32'd1;
    end else if (kaz == 1) begin
      e = '{sahip: 1'b1, adres: vadr, yaz: vyaz, veri: vveri, maske: vmaske};
      istek_q.push_back(e);
      son_m = 1'b1;
      sayac_v_m = sayac_v_m + 32'd1;
    end
    saat();
    l1b_istek_gecerli_i = 1'b0;
    l1v_istek_gecerli_i = 1'b0;
  endtask

  // Play memory: hold off the request, then the owner's response acceptance, comparing throughout
  task automatic hizmet(input logic [127:0] yveri, input int istek_bekle, input int yanit_bekle, input bit kes);
    beklenen_t e;
    if (istek_q.size() == 0) begin
      kontrol("kuyruk_bos", 1'b1, 1'b0);
      return;
    end
    e = istek_q.pop_front();
    for (int i = 0; i <= istek_bekle; i++) begin
      bellek_istek_hazir_i = (i == istek_bekle);
      #1;
      kontrol("istek_gecerli", bellek_istek_gecerli_o, 1'b1);
      kontrol("istek_adres", bellek_istek_adres_o, e.adres);
      kontrol("istek_yaz", bellek_istek_yaz_o, e.yaz);
      kontrol("istek_veri", bellek_istek_veri_o, e.veri);
      kontrol("istek_maske", bellek_istek_maske_o, e.maske);
      kontrol("istek_hazir_yok", {l1v_istek_hazir_o, l1b_istek_hazir_o}, 2'b00);
      saat();
    end
    bellek_istek_hazir_i = 1'b0;
    if (kes) return;
    kontrol("istek_dustu", bellek_istek_gecerli_o, 1'b0);
    bellek_yanit_gecerli_i = 1'b1;
    bellek_yanit_veri_i    = yveri;
    for (int i = 0; i <= yanit_bekle; i++) begin
      // Non-owner is always ready so wrong routing of hazir would show up
      l1b_yanit_hazir_i = (e.sahip == 1'b0) ? (i == yanit_bekle) : 1'b1;
      l1v_yanit_hazir_i = (e.sahip == 1'b1) ? (i == yanit_bekle) : 1'b1;
      #1;
      kontrol("yanit_gecerli", {l1v_yanit_gecerli_o, l1b_yanit_gecerli_o}, e.sahip ? 2'b10 : 2'b01);
      kontrol("bellek_yanit_hazir", bellek_yanit_hazir_o, i == yanit_bekle);
      kontrol("yanit_hazir_yok", {l1v_istek_hazir_o, l1b_istek_hazir_o}, 2'b00);
      if (!e.yaz) kontrol("yanit_veri", e.sahip ? l1v_yanit_veri_o : l1b_yanit_veri_o, yveri);
      saat();
    end
    bellek_yanit_gecerli_i = 1'b0;
    l1b_yanit_hazir_i = 1'b0;
    l1v_yanit_hazir_i = 1'b0;
    kontrol("sayac_b", l1b_istek_sayac_o, sayac_b_m);
    kontrol("sayac_v", l1v_istek_sayac_o, sayac_v_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    l1b_istek_gecerli_i = 1'b0; l1b_istek_adres_i = 32'd0; l1b_yanit_hazir_i = 1'b0;
    l1v_istek_gecerli_i = 1'b0; l1v_istek_adres_i = 32'd0; l1v_istek_yaz_i = 1'b0;
    l1v_istek_veri_i = 128'd0;  l1v_istek_maske_i = 16'd0; l1v_yanit_hazir_i = 1'b0;
    bellek_istek_hazir_i = 1'b0; bellek_yanit_gecerli_i = 1'b0; bellek_yanit_veri_i = 128'd0;
    model_sifirla();
    sifirla();

    // 1: lone L1B read
    tahkim(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 128'd0, 16'd0);
    hizmet({4{32'hDEAD_BEEF}}, 0, 0, 1'b0);

    // 2: both requesting after reset alternate L1B, L1V, L1B
    sifirla();
    tahkim(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 128'd0, 16'd0);
    hizmet(128'h1111, 0, 0, 1'b0);
    tahkim(1'b1, 1'b1, 32'h0000_1040, 32'h0000_2000, 1'b0, 128'd0, 16'd0);
    hizmet(128'h2222, 0, 0, 1'b0);
    tahkim(1'b1, 1'b1, 32'h0000_1080, 32'h0000_2040, 1'b0, 128'd0, 16'd0);
    hizmet(128'h3333, 0, 0, 1'b0);

    // 3: L1V writeback stalled 5 cycles by memory
    tahkim(1'b0, 1'b1, 32'd0, 32'h0000_0100, 1'b1, {4{32'hCAFE_F00D}}, 16'hFFFF);
    hizmet(128'd0, 5, 0, 1'b0);

    // 4: L1V read with owner stalling the response 3 cycles while L1B waits
    tahkim(1'b0, 1'b1, 32'd0, 32'h0000_0200, 1'b0, 128'd0, 16'h00FF);
    l1b_istek_gecerli_i = 1'b1;
    l1b_istek_adres_i   = 32'h0000_0300;
    hizmet(128'h4444_5555, 0, 3, 1'b0);
    tahkim(1'b1, 1'b0, 32'h0000_0300, 32'd0, 1'b0, 128'd0, 16'd0);
    hizmet(128'h6666, 0, 0, 1'b0);

    // 5: reset in YANIT, then normal L1V grant
    tahkim(1'b0, 1'b1, 32'd0, 32'h0000_0400, 1'b0, 128'd0, 16'd0);
    hizmet(128'd0, 0, 0, 1'b1);
    bellek_yanit_gecerli_i = 1'b1;
    bellek_yanit_veri_i    = 128'h7777;
    #1;
    kontrol("yanit_once_rst", l1v_yanit_gecerli_o, 1'b1);
    rst_i = 1'b1;
    saat();
    rst_i = 1'b0;
    model_sifirla();
    kontrol("rst_yanit_gecerli", {l1v_yanit_gecerli_o, l1b_yanit_gecerli_o}, 2'b00);
    kontrol("rst_bellek_hazir", bellek_yanit_hazir_o, 1'b0);
    kontrol("rst_istek", bellek_istek_gecerli_o, 1'b0);
    kontrol("rst_sayac", {l1b_istek_sayac_o, l1v_istek_sayac_o}, 64'd0);
    bellek_yanit_gecerli_i = 1'b0;
    tahkim(1'b0, 1'b1, 32'd0, 32'h0000_0500, 1'b0, 128'd0, 16'd0);
    hizmet(128'h8888, 0, 0, 1'b0);

    // 6: L1B counter wrap on grant
    force dut.l1b_sayac_r = 32'hFFFF_FFFF;
    #1;
    release dut.l1b_sayac_r;
    sayac_b_m = 32'hFFFF_FFFF;
    kontrol("sayac_yukle", l1b_istek_sayac_o, 32'hFFFF_FFFF);
    tahkim(1'b1, 1'b0, 32'h0000_0600, 32'd0, 1'b0, 128'd0, 16'd0);
    kontrol("sayac_tasma", l1b_istek_sayac_o, 32'd0);
    hizmet(128'h9999, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
    $finish;
  end

endmodule
